rom_dl_ctrl: RTL and testbench

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

---
 rtl/rom_dl_pkg.sv | 18 +
 rtl/rom_dl_checksum.sv | 36 +++
 rtl/rom_dl_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rom_dl_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared state encoding and ROM map constants for the ROM download controller.
package rom_dl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } dl_state_e;

  localparam logic [19:0] ROM_MAIN_BASE  = 20'h00000;
  localparam logic [19:0] ROM_SUB_BASE   = 20'h10000;
  localparam logic [19:0] ROM_SOUND_BASE = 20'h20000;
  localparam logic [19:0] ROM_END        = 20'h2C000;
  localparam logic [19:0] BYTE_COUNT_MAX = 20'hFFFFF;

endpackage

// File: rtl/rom_dl_checksum.sv
// Additive 16-bit byte accumulator with synchronous clear and enable.
module rom_dl_checksum (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q, sum_d;

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 16'h0000;
    end else if (en_i) begin
      sum_d = sum_q + {8'h00, data_i};
    end else begin
      sum_d = sum_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 16'h0000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rom_dl_ctrl.sv
// HPS ROM download controller: forwards accepted bytes, validates the set and
// gates the core reset. Define ROM_DL_CHECKSUM_EN to enable the byte checksum.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX     = 8'h00,
  parameter logic [19:0] EXPECTED_SIZE = ROM_END
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic        IOCTL_WR,
  input  logic [19:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  output logic        DL_WR,
  output logic [19:0] DL_ADDR,
  output logic [7:0]  DL_DATA,
  output logic [19:0] BYTE_COUNT,
  output logic        ROMS_READY,
  output logic        CORE_RESET_HOLD,
  output logic        DL_ERROR,
  output logic [15:0] DL_CHECKSUM
);

  dl_state_e   state_q, state_d;
  logic        dl_wr_q, dl_wr_d;
  logic [19:0] dl_addr_q, dl_addr_d;
  logic [7:0]  dl_data_q, dl_data_d;
  logic [19:0] byte_count_q, byte_count_d;
  logic        dl_error_q, dl_error_d;
  logic        roms_ready_q, roms_ready_d;
  logic        core_hold_q, core_hold_d;

  logic        index_match_s;
  logic        start_s;
  logic        load_wr_s;
  logic        accept_s;
  logic        overflow_s;
  logic        clear_s;

  assign index_match_s = (IOCTL_INDEX == ROM_INDEX);
  assign start_s       = IOCTL_DOWNLOAD && index_match_s;
  assign load_wr_s     = (state_q == LOAD) && IOCTL_WR && index_match_s;
  assign accept_s      = load_wr_s && (IOCTL_ADDR < EXPECTED_SIZE);
  assign overflow_s    = load_wr_s && (IOCTL_ADDR >= EXPECTED_SIZE);
  // Any entry into LOAD starts a fresh set, including restarts from DONE/ERROR.
  assign clear_s       = (state_q != LOAD) && (state_d == LOAD);

  // Next-state logic for the download sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!IOCTL_DOWNLOAD) begin
          state_d = CHECK;
        end else begin
          state_d = LOAD;
        end
      end
      CHECK: begin
        if ((byte_count_q == EXPECTED_SIZE) && !dl_error_q) begin
          state_d = DONE;
        end else begin
          state_d = ERROR;
        end
      end
      DONE: begin
        if (start_s) begin
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      ERROR: begin
        if (start_s) begin
          state_d = LOAD;
        end else begin
          state_d = ERROR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and status next values; status flags decode the next state so
  // they switch on the same edge as the state itself.
  always_comb begin
    dl_wr_d      = accept_s;
    dl_addr_d    = dl_addr_q;
    dl_data_d    = dl_data_q;
    byte_count_d = byte_count_q;
    dl_error_d   = dl_error_q;
    roms_ready_d = (state_d == DONE);
    core_hold_d  = (state_d != DONE);

    if (accept_s) begin
      dl_addr_d = IOCTL_ADDR;
      dl_data_d = IOCTL_DOUT;
    end else begin
      dl_addr_d = dl_addr_q;
      dl_data_d = dl_data_q;
    end

    if (clear_s) begin
      byte_count_d = 20'h00000;
    end else if (accept_s && (byte_count_q != BYTE_COUNT_MAX)) begin
      byte_count_d = byte_count_q + 20'h00001;
    end else begin
      byte_count_d = byte_count_q;
    end

    if (clear_s) begin
      dl_error_d = 1'b0;
    end else if (overflow_s) begin
      dl_error_d = 1'b1;
    end else if ((state_q == CHECK) && (state_d == ERROR)) begin
      dl_error_d = 1'b1;
    end else begin
      dl_error_d = dl_error_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= IDLE;
      dl_wr_q      <= 1'b0;
      dl_addr_q    <= 20'h00000;
      dl_data_q    <= 8'h00;
      byte_count_q <= 20'h00000;
      dl_error_q   <= 1'b0;
      roms_ready_q <= 1'b0;
      core_hold_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      dl_wr_q      <= dl_wr_d;
      dl_addr_q    <= dl_addr_d;
      dl_data_q    <= dl_data_d;
      byte_count_q <= byte_count_d;
      dl_error_q   <= dl_error_d;
      roms_ready_q <= roms_ready_d;
      core_hold_q  <= core_hold_d;
    end
  end

  assign DL_WR           = dl_wr_q;
  assign DL_ADDR         = dl_addr_q;
  assign DL_DATA         = dl_data_q;
  assign BYTE_COUNT      = byte_count_q;
  assign DL_ERROR        = dl_error_q;
  assign ROMS_READY      = roms_ready_q;
  assign CORE_RESET_HOLD = core_hold_q;

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] checksum_s;

  rom_dl_checksum u_checksum (
    .clk_i  (CLK),
    .rst_ni (RESET_n),
    .clr_i  (clear_s),
    .en_i   (accept_s),
    .data_i (IOCTL_DOUT),
    .sum_o  (checksum_s)
  );

  assign DL_CHECKSUM = checksum_s;
`else
  assign DL_CHECKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Randomized scoreboard bench for rom_dl_ctrl with a reduced ROM set size.
module tb_rom_dl_ctrl;

  localparam logic [7:0]  ROM_IDX = 8'h00;
  localparam logic [19:0] SZ      = 20'h00400;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        IOCTL_DOWNLOAD = 1'b0;
  logic [7:0]  IOCTL_INDEX = 8'h00;
  logic        IOCTL_WR = 1'b0;
  logic [19:0] IOCTL_ADDR = 20'h00000;
  logic [7:0]  IOCTL_DOUT = 8'h00;
  logic        DL_WR;
  logic [19:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic [19:0] BYTE_COUNT;
  logic        ROMS_READY;
  logic        CORE_RESET_HOLD;
  logic        DL_ERROR;
  logic [15:0] DL_CHECKSUM;

  rom_dl_ctrl #(.ROM_INDEX(ROM_IDX), .EXPECTED_SIZE(SZ)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD),
    .IOCTL_INDEX(IOCTL_INDEX), .IOCTL_WR(IOCTL_WR), .IOCTL_ADDR(IOCTL_ADDR),
    .IOCTL_DOUT(IOCTL_DOUT), .DL_WR(DL_WR), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA),
    .BYTE_COUNT(BYTE_COUNT), .ROMS_READY(ROMS_READY),
    .CORE_RESET_HOLD(CORE_RESET_HOLD), .DL_ERROR(DL_ERROR),
    .DL_CHECKSUM(DL_CHECKSUM)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] a;
    logic [7:0]  d;
    int          c;
  } exp_t;

  typedef struct {
    logic [19:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a set is good when exactly SZ in-range bytes arrived and
  // nothing out of range was written.
  bit   m_load = 0;
  int   m_cnt  = 0;
  bit   m_err  = 0;
  bit   m_done = 0;
  int   m_sum  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_cksum();
`ifdef ROM_DL_CHECKSUM_EN
    return 16'(m_sum & 32'h0000FFFF);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [19:0] exp_count();
    if (m_cnt > 32'h000FFFFF) return 20'hFFFFF;
    return 20'(m_cnt);
  endfunction

  task automatic model_reset();
    m_load = 0; m_cnt = 0; m_err = 0; m_done = 0; m_sum = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus plus the matching model update.
  task automatic step(input bit dl, input logic [7:0] idx, input bit wr,
                      input logic [19:0] a, input logic [7:0] d);
    IOCTL_DOWNLOAD = dl;
    IOCTL_INDEX    = idx;
    IOCTL_WR       = wr;
    IOCTL_ADDR     = a;
    IOCTL_DOUT     = d;
    if (m_load) begin
      if (wr && (idx == ROM_IDX)) begin
        if (a < SZ) begin
          exp_q.push_back('{a: a, d: d, c: cyc + 1});
          m_cnt++;
          m_sum += int'(d);
        end else begin
          m_err = 1;
        end
      end
      if (!dl) begin
        m_load = 0;
        m_done = (m_cnt == int'(SZ)) && !m_err;
        if (!m_done) m_err = 1;
      end
    end else if (dl && (idx == ROM_IDX)) begin
      m_load = 1; m_cnt = 0; m_err = 0; m_done = 0; m_sum = 0;
    end
    @(posedge CLK);
    #1;
    IOCTL_WR = 1'b0;
  endtask

  task automatic check_outcome(input string tag);
    chk({tag, ".byte_count"}, 32'(BYTE_COUNT), 32'(exp_count()));
    chk({tag, ".dl_error"}, 32'(DL_ERROR), 32'(m_err));
    chk({tag, ".roms_ready"}, 32'(ROMS_READY), 32'(m_done));
    chk({tag, ".core_reset_hold"}, 32'(CORE_RESET_HOLD), 32'(!m_done));
    chk({tag, ".dl_checksum"}, 32'(DL_CHECKSUM), 32'(exp_cksum()));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".dl_wr"}, 32'(DL_WR), 32'h0);
    chk({tag, ".dl_addr"}, 32'(DL_ADDR), 32'h0);
    chk({tag, ".dl_data"}, 32'(DL_DATA), 32'h0);
    chk({tag, ".byte_count"}, 32'(BYTE_COUNT), 32'h0);
    chk({tag, ".dl_error"}, 32'(DL_ERROR), 32'h0);
    chk({tag, ".dl_checksum"}, 32'(DL_CHECKSUM), 32'h0);
    chk({tag, ".roms_ready"}, 32'(ROMS_READY), 32'h0);
    chk({tag, ".core_reset_hold"}, 32'(CORE_RESET_HOLD), 32'h1);
  endtask

  // Runs one matching download. The last byte shares its cycle with the
  // falling download level. abort_at >= 0 asserts reset after that many bytes.
  task automatic run_download(input string tag, input wr_t wq[$], input int abort_at);
    step(1'b1, ROM_IDX, 1'b0, 20'h0, 8'h0);
    chk({tag, ".start_ready_low"}, 32'(ROMS_READY), 32'h0);
    chk({tag, ".start_count_clr"}, 32'(BYTE_COUNT), 32'h0);
    chk({tag, ".start_err_clr"}, 32'(DL_ERROR), 32'h0);
    for (int i = 0; i < wq.size(); i++) begin
      if (i == abort_at) begin
        RESET_n = 1'b0;
        #1;
        check_reset_values({tag, ".abort"});
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_n = 1'b1;
        return;
      end
      if ($urandom_range(3) == 0) step(1'b1, ROM_IDX, 1'b0, 20'h0, 8'h0);
      step((i != wq.size() - 1), ROM_IDX, 1'b1, wq[i].a, wq[i].d);
    end
    if (wq.size() == 0) step(1'b0, ROM_IDX, 1'b0, 20'h0, 8'h0);
    chk({tag, ".check_hold"}, 32'(CORE_RESET_HOLD), 32'h1);
    chk({tag, ".check_ready"}, 32'(ROMS_READY), 32'h0);
    step(1'b0, ROM_IDX, 1'b0, 20'h0, 8'h0);
    check_outcome(tag);
    step(1'b0, ROM_IDX, 1'b0, 20'h0, 8'h0);
  endtask

  function automatic void make_seq(output wr_t wq[$], input int n, input bit rnd_addr);
    wq.delete();
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = rnd_addr ? 20'($urandom_range(int'(SZ) - 1)) : 20'(i);
      w.d = 8'($urandom_range(255));
      wq.push_back(w);
    end
  endfunction

  // Monitor: every DL_WR must match the oldest expected byte, one cycle late.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_n && DL_WR) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dl_wr_unexpected: got DL_WR addr %0h, expected no write (cycle %0d)", DL_ADDR, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("dl_addr", 32'(DL_ADDR), 32'(e.a));
          chk("dl_data", 32'(DL_DATA), 32'(e.d));
          chk("dl_wr_latency", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  initial begin
    wr_t wq[$];
    int  n;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RESET_n = 1'b1;
    step(1'b0, ROM_IDX, 1'b0, 20'h0, 8'h0);

    make_seq(wq, int'(SZ), 1'b0);
    run_download("full", wq, -1);

    for (int i = 0; i < 6; i++)
      step(1'b1, 8'h01, 1'b1, 20'(i), 8'($urandom_range(255)));
    step(1'b0, 8'h01, 1'b0, 20'h0, 8'h0);
    check_outcome("other_index");

    make_seq(wq, int'(SZ), 1'b1);
    run_download("dup_addr", wq, -1);

    make_seq(wq, (int'(SZ) * 3) / 4, 1'b0);
    run_download("short", wq, -1);

    make_seq(wq, int'(SZ), 1'b0);
    wq.insert(int'(SZ) / 2, '{a: SZ, d: 8'h5A});
    run_download("overflow", wq, -1);

    make_seq(wq, int'(SZ), 1'b0);
    run_download("abort", wq, int'(SZ) / 2);
    make_seq(wq, int'(SZ), 1'b0);
    run_download("reload", wq, -1);

    wq.delete();
    wq.push_back('{a: 20'h00000, d: 8'hFF});
    wq.push_back('{a: 20'h00001, d: 8'h01});
    wq.push_back('{a: 20'h00002, d: 8'h10});
    run_download("cksum", wq, -1);
`ifdef ROM_DL_CHECKSUM_EN
    chk("cksum.value", 32'(DL_CHECKSUM), 32'h0110);
`else
    chk("cksum.value", 32'(DL_CHECKSUM), 32'h0000);
`endif

    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(2))
        0:       n = int'(SZ);
        1:       n = int'(SZ) - 1 - int'($urandom_range(20));
        default: n = int'(SZ) + 1 + int'($urandom_range(20));
      endcase
      make_seq(wq, n, 1'($urandom_range(1)));
      if ($urandom_range(2) == 0)
        wq.insert($urandom_range(wq.size() - 1), '{a: SZ + 20'($urandom_range(64)), d: 8'hA5});
      run_download("random", wq, -1);
    end

    chk("pending_writes", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
